// File: rtl/arbiter_stream_mux.sv
// Packet mux behind a round-robin arbiter: requests on behalf of N valid/ready input streams and
// forwards each granted packet whole to a single output stream through a 2-entry skid buffer.
module arbiter_stream_mux #(
  parameter int NUM_PORTS  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [0:NUM_PORTS-1]            in_valid,
  input  logic [0:NUM_PORTS-1]            in_last,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [0:NUM_PORTS-1]            in_ready,
  output logic [0:NUM_PORTS-1]            arb_req,
  input  logic [0:NUM_PORTS-1]            arb_grant,
  input  logic                            arb_active,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [SEL_WIDTH-1:0]            out_port,
  input  logic                            out_ready
);

  typedef enum logic [1:0] { IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2 } state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
    logic [SEL_WIDTH-1:0]  port;
  } beat_t;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [1:0]            count_q, count_d;
  beat_t                 head_q, head_d, tail_q, tail_d;

  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  grant_hit, sel_valid, sel_last, sel_grant;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  can_accept, push, pop;
  beat_t                 push_beat;

  // Grant-to-index encoding and selection of the currently latched port's input signals.
  always_comb begin
    grant_idx = '0;
    grant_hit = 1'b0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_grant = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_hit && arb_grant[i]) begin
        grant_idx = SEL_WIDTH'(i);
        grant_hit = 1'b1;
      end
      if (sel_q == SEL_WIDTH'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_grant = arb_grant[i];
        sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // in_ready depends only on flops, so out_ready never reaches the input side combinationally.
  assign can_accept = (state_q == XFER) && (count_q < 2'd2);
  assign push       = can_accept && sel_valid;
  assign pop        = (count_q != 2'd0) && out_ready;
  assign push_beat  = '{last: sel_last, data: sel_data, port: sel_q};

  // Per-port ready and request vectors; the latched port's request is masked while its grant clears.
  always_comb begin
    in_ready = '0;
    arb_req  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = can_accept && (sel_q == SEL_WIDTH'(i));
      arb_req[i]  = !rst && in_valid[i] && !((state_q == DRAIN) && (sel_q == SEL_WIDTH'(i)));
    end
  end

  // Packet sequencing: take a grant, stream until the last beat, then wait out the stale grant.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (arb_active && grant_hit) begin
          state_d = XFER;
          sel_d   = grant_idx;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (push && sel_last) state_d = DRAIN;
        else                  state_d = XFER;
      end
      DRAIN: begin
        if (!sel_grant) state_d = IDLE;
        else            state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry FIFO; head is the output register, tail only fills while the head is stalled.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_beat;
        else                 tail_d = push_beat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_beat;
        end else begin
          head_d = tail_q;
          tail_d = push_beat;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // State, selection and skid storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_last  = head_q.last;
  assign out_data  = head_q.data;
  assign out_port  = head_q.port;

endmodule

// File: tb/tb_arbiter_stream_mux.sv
// Bench for arbiter_stream_mux: a round-robin arbiter model and per-port packet sources drive the
// mux; delivered beats are compared against whole packets ordered by round-robin rounds.
`timescale 1ns/1ps
module tb_arbiter_stream_mux;
  localparam int NP = 6;
  localparam int DW = 32;
  localparam int SW = 3;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
    logic [SW-1:0] port;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [0:NP-1]   in_valid, in_last, in_ready, arb_req, arb_grant;
  logic [NP*DW-1:0] in_data;
  logic            arb_active, out_valid, out_last, out_ready;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_port;

  int total = 0;
  int bad   = 0;
  beat_t src_q [NP][$];
  beat_t exp_q [$];
  beat_t obs_q [$];
  int    obs_cyc [$];
  int ready_mode = 0;
  int rcnt = 0;
  int cyc = 0;
  int unstable_cnt = 0;
  int full_viol = 0;
  int occ = 0;
  int occ_max = 0;
  int rr_last = NP - 1;

  arbiter_stream_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .arb_req(arb_req), .arb_grant(arb_grant), .arb_active(arb_active),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_port(out_port),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  assign arb_active = |arb_grant;

  function automatic beat_t mk(input logic l, input logic [DW-1:0] d, input int p);
    beat_t b;
    b.last = l;
    b.data = d;
    b.port = SW'(p);
    return b;
  endfunction

  // Arbiter model, packet sources, out_ready pattern and output capture.
  initial begin : bfm
    logic [0:NP-1] hs, req_s;
    logic pop_s, stall_prev, found;
    beat_t held;
    int p;
    in_valid = '0; in_last = '0; in_data = '0; arb_grant = '0; out_ready = 1'b1;
    stall_prev = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      hs    = in_valid & in_ready;
      req_s = arb_req;
      pop_s = out_valid & out_ready;
      if (stall_prev && !rst && (!out_valid || mk(out_last, out_data, int'(out_port)) != held))
        unstable_cnt++;
      if (rst) begin
        occ = 0;
      end else begin
        if (pop_s) begin
          obs_q.push_back(mk(out_last, out_data, int'(out_port)));
          obs_cyc.push_back(cyc);
        end
        if (occ == 2 && |in_ready) full_viol++;
        occ = occ + $countones(hs) - (pop_s ? 1 : 0);
        if (occ > occ_max) occ_max = occ;
      end
      stall_prev = out_valid & ~out_ready & ~rst;
      held = mk(out_last, out_data, int'(out_port));

      @(posedge clk);
      #1;
      if (rst) begin
        arb_grant = '0;
        rr_last = NP - 1;
      end else if (!(|(arb_grant & req_s))) begin
        arb_grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          p = (rr_last + k) % NP;
          if (!found && req_s[p]) begin
            arb_grant[p] = 1'b1;
            rr_last = p;
            found = 1'b1;
          end
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          in_valid[i] = 1'b1;
          in_last[i]  = src_q[i][0].last;
          in_data[i*DW +: DW] = src_q[i][0].data;
        end else begin
          in_valid[i] = 1'b0;
          in_last[i]  = 1'b0;
          in_data[i*DW +: DW] = '0;
        end
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (rcnt % 3 == 0); rcnt++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic clear_all();
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #2;
    rst = 1'b1;
    clear_all();
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
    rcnt = 0; unstable_cnt = 0; full_viol = 0; occ_max = 0;
  endtask

  task automatic add_pkt(input int p, input int len, input logic [DW-1:0] base, input bit rnd);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b = mk(j == len - 1, rnd ? $urandom : base + DW'(j), p);
      src_q[p].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int c = 0; c < budget && obs_q.size() < n; c++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    beat_t g;
    @(posedge clk); #2;
    rst = 1'b1; ready_mode = 0;
    clear_all();
    for (int p = 0; p < NP; p++) add_pkt(p, 1, '0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++; if (arb_req !== 6'b000000) begin bad++; $display("FAIL reset_arb_req: got %b want 000000", arb_req); end
      total++; if (in_ready !== 6'b000000) begin bad++; $display("FAIL reset_in_ready: got %b want 000000", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    end
    #1; rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      total++;
      if (out_valid !== (c == 3)) begin bad++; $display("FAIL reset_latency c%0d: got out_valid=%b want %b", c, out_valid, c == 3); end
      if (c == 0) begin
        total++; if (arb_req !== 6'b111111) begin bad++; $display("FAIL reset_req_after: got %b want 111111", arb_req); end
      end
    end
    wait_obs(NP, 300);
    for (int j = 0; j < exp_q.size(); j++) begin
      g = 'x; if (j < obs_q.size()) g = obs_q[j];
      total++; if (g !== exp_q[j]) begin bad++; $display("FAIL reset_beat[%0d]: got %h want %h", j, g, exp_q[j]); end
    end
  endtask

  task automatic test_single_port();
    beat_t g;
    do_reset(2); ready_mode = 0;
    add_pkt(2, 4, 32'hA0, 1'b0);
    wait_obs(4, 200);
    for (int j = 0; j < 4; j++) begin
      g = 'x; if (j < obs_q.size()) g = obs_q[j];
      total++; if (g !== exp_q[j]) begin bad++; $display("FAIL single_beat[%0d]: got %h want %h", j, g, exp_q[j]); end
      if (j > 0 && j < obs_cyc.size()) begin
        total++; if (obs_cyc[j] - obs_cyc[0] != j) begin bad++; $display("FAIL single_gap[%0d]: got %0d want %0d", j, obs_cyc[j] - obs_cyc[0], j); end
      end
    end
  endtask

  task automatic test_round_robin();
    beat_t g;
    bit seen;
    int k;
    do_reset(2); ready_mode = 0;
    add_pkt(0, 2, '0, 1'b1);
    add_pkt(3, 2, '0, 1'b1);
    add_pkt(0, 2, '0, 1'b1);
    seen = 1'b0; k = 0;
    for (int c = 0; c < 300 && obs_q.size() < 6; c++) begin
      @(negedge clk); #1;
      if (k > 0) begin
        total++;
        if (arb_req[0] !== 1'b0 || in_valid[0] !== 1'b1) begin bad++; $display("FAIL rr_drain_mask: got req0=%b valid0=%b want 0 1", arb_req[0], in_valid[0]); end
        k--;
      end
      if (!seen && in_valid[0] && in_ready[0] && in_last[0]) begin seen = 1'b1; k = 2; end
    end
    total++; if (!seen) begin bad++; $display("FAIL rr_last_seen: got 0 want 1"); end
    for (int j = 0; j < exp_q.size(); j++) begin
      g = 'x; if (j < obs_q.size()) g = obs_q[j];
      total++; if (g !== exp_q[j]) begin bad++; $display("FAIL rr_beat[%0d]: got %h want %h", j, g, exp_q[j]); end
    end
  endtask

  task automatic test_backpressure();
    beat_t g;
    do_reset(2); ready_mode = 1;
    add_pkt(int'($urandom_range(0, NP - 1)), 8, '0, 1'b1);
    wait_obs(8, 500);
    for (int j = 0; j < 8; j++) begin
      g = 'x; if (j < obs_q.size()) g = obs_q[j];
      total++; if (g !== exp_q[j]) begin bad++; $display("FAIL bp_beat[%0d]: got %h want %h", j, g, exp_q[j]); end
    end
    total++; if (unstable_cnt != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable_cnt); end
    total++; if (full_viol != 0) begin bad++; $display("FAIL bp_full_ready: got %0d want 0", full_viol); end
    total++; if (occ_max != 2) begin bad++; $display("FAIL bp_occupancy: got %0d want 2", occ_max); end
  endtask

  task automatic test_single_beat_all();
    beat_t g;
    do_reset(2); ready_mode = 0;
    for (int p = 0; p < NP; p++) add_pkt(p, 1, '0, 1'b1);
    wait_obs(NP, 400);
    for (int j = 0; j < NP; j++) begin
      g = 'x; if (j < obs_q.size()) g = obs_q[j];
      total++; if (g !== exp_q[j]) begin bad++; $display("FAIL sb_beat[%0d]: got %h want %h", j, g, exp_q[j]); end
    end
  endtask

  task automatic test_reset_mid();
    beat_t g;
    int p, q;
    do_reset(2); ready_mode = 0;
    p = int'($urandom_range(0, NP - 1));
    q = (p + 1 + int'($urandom_range(0, NP - 2))) % NP;
    add_pkt(p, 5, '0, 1'b1);
    wait_obs(2, 200);
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL mid_count: got %0d want 2", obs_q.size()); end
    for (int j = 0; j < 2; j++) begin
      g = 'x; if (j < obs_q.size()) g = obs_q[j];
      total++; if (g !== exp_q[j]) begin bad++; $display("FAIL mid_beat[%0d]: got %h want %h", j, g, exp_q[j]); end
    end
    do_reset(1); ready_mode = 0;
    add_pkt(q, 3, '0, 1'b1);
    wait_obs(3, 200);
    repeat (8) @(negedge clk);
    #1;
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL mid_new_count: got %0d want 3", obs_q.size()); end
    for (int j = 0; j < 3; j++) begin
      g = 'x; if (j < obs_q.size()) g = obs_q[j];
      total++; if (g !== exp_q[j]) begin bad++; $display("FAIL mid_new_beat[%0d]: got %h want %h", j, g, exp_q[j]); end
    end
  endtask

  task automatic test_random();
    beat_t g;
    int npk [NP];
    int n;
    for (int r = 0; r < 3; r++) begin
      do_reset(1); ready_mode = 2;
      for (int p = 0; p < NP; p++) npk[p] = int'($urandom_range(0, 2));
      npk[int'($urandom_range(0, NP - 1))] = 2;
      for (int rnd = 0; rnd < 2; rnd++)
        for (int p = 0; p < NP; p++)
          if (rnd < npk[p]) add_pkt(p, int'($urandom_range(1, 4)), '0, 1'b1);
      n = exp_q.size();
      wait_obs(n, 3000);
      repeat (10) @(negedge clk);
      #1;
      total++; if (obs_q.size() != n) begin bad++; $display("FAIL rand_count r%0d: got %0d want %0d", r, obs_q.size(), n); end
      for (int j = 0; j < n; j++) begin
        g = 'x; if (j < obs_q.size()) g = obs_q[j];
        total++; if (g !== exp_q[j]) begin bad++; $display("FAIL rand_beat r%0d[%0d]: got %h want %h", r, j, g, exp_q[j]); end
      end
      total++; if (unstable_cnt != 0) begin bad++; $display("FAIL rand_stable r%0d: got %0d want 0", r, unstable_cnt); end
      total++; if (full_viol != 0) begin bad++; $display("FAIL rand_full_ready r%0d: got %0d want 0", r, full_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_single_beat_all();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
